// File: rtl/md_router.sv
// md_router: routes an AXI-Stream metadata beat to NCH registered channels (broadcast or selector field), framing BURST_LEN-beat packets per channel.
// Define MD_ROUTER_STATS_EN to add per-channel delivered-beat and dropped-beat counters.
module md_router #(
    parameter int DW        = 512,
    parameter int NCH       = 2,
    parameter int MODE      = 0,
    parameter int SEL_LSB   = 0,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     AXIS_IN_MD_TDATA,
    input  logic              AXIS_IN_MD_TVALID,
    output logic              AXIS_IN_MD_TREADY,
    output logic [NCH*DW-1:0] AXIS_OUT_MD_TDATA,
    output logic [NCH-1:0]    AXIS_OUT_MD_TVALID,
    input  logic [NCH-1:0]    AXIS_OUT_MD_TREADY,
    output logic [NCH-1:0]    AXIS_OUT_MD_TLAST,
    output logic [NCH*32-1:0] stat_beats,
    output logic [31:0]       stat_drops
);
    localparam int SEL_W = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

    logic [NCH-1:0]   can_load, load, drain;
    logic [SEL_W-1:0] sel;
    logic             in_range, accept;

    assign can_load = ~AXIS_OUT_MD_TVALID | AXIS_OUT_MD_TREADY;
    assign drain    = AXIS_OUT_MD_TVALID & AXIS_OUT_MD_TREADY;
    assign sel      = AXIS_IN_MD_TDATA[SEL_LSB +: SEL_W];
    assign in_range = 32'(sel) < NCH;
    assign accept   = AXIS_IN_MD_TVALID & AXIS_IN_MD_TREADY;

    // Out-of-range selectors are always accepted so they can be discarded without stalling.
    always_comb begin
        AXIS_IN_MD_TREADY = MODE == 0 ? &can_load : (in_range ? can_load[sel] : 1'b1);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] data;
        logic          vld, lst;
        logic [15:0]   bcnt;
        assign load[c] = accept && (MODE == 0 || (in_range && 32'(sel) == c));
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data <= '0;
                vld  <= 1'b0;
                lst  <= 1'b0;
                bcnt <= '0;
            end else if (load[c]) begin
                data <= AXIS_IN_MD_TDATA;
                vld  <= 1'b1;
                lst  <= bcnt == LAST_CNT;
                bcnt <= bcnt == LAST_CNT ? '0 : bcnt + 16'd1;
            end else if (drain[c]) begin
                vld <= 1'b0;
            end
        end
        assign AXIS_OUT_MD_TDATA[c*DW +: DW] = data;
        assign AXIS_OUT_MD_TVALID[c]         = vld;
        assign AXIS_OUT_MD_TLAST[c]          = lst;
`ifdef MD_ROUTER_STATS_EN
        logic [31:0] beats;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) beats <= '0;
            else if (drain[c]) beats <= beats + 32'd1;
        end
        assign stat_beats[c*32 +: 32] = beats;
`else
        assign stat_beats[c*32 +: 32] = '0;
`endif
    end

`ifdef MD_ROUTER_STATS_EN
    logic        drop;
    logic [31:0] drops;
    assign drop = accept && MODE == 1 && !in_range;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drops <= '0;
        else if (drop) drops <= drops + 32'd1;
    end
    assign stat_drops = drops;
`else
    assign stat_drops = '0;
`endif
endmodule

// File: tb/tb_md_router.sv
// tb_md_router: self-checking bench with a broadcast instance (NCH=3, BURST_LEN=4) and a select instance (NCH=3, BURST_LEN=3).
// A slot-per-channel reference model is compared against both instances every cycle.
module tb_md_router;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid [2];
    logic [15:0] in_data [2];
    logic        in_ready [2];
    logic [47:0] out_data [2];
    logic [2:0]  out_valid [2];
    logic [2:0]  out_last [2];
    logic [2:0]  out_ready [2];
    logic [95:0] sb [2];
    logic [31:0] sd [2];
    int total = 0;
    int bad = 0;

    logic [2:0]  occ [2];
    logic [15:0] md [2][3];
    logic        ml [2][3];
    int          mc [2][3];
    int          mb [2][3];
    int          mdrop [2];

    always #5 clk = ~clk;

    md_router #(.DW(16), .NCH(3), .MODE(0), .SEL_LSB(0), .BURST_LEN(4)) u_bc (
        .clk(clk), .reset(reset),
        .AXIS_IN_MD_TDATA(in_data[0]), .AXIS_IN_MD_TVALID(in_valid[0]), .AXIS_IN_MD_TREADY(in_ready[0]),
        .AXIS_OUT_MD_TDATA(out_data[0]), .AXIS_OUT_MD_TVALID(out_valid[0]),
        .AXIS_OUT_MD_TREADY(out_ready[0]), .AXIS_OUT_MD_TLAST(out_last[0]),
        .stat_beats(sb[0]), .stat_drops(sd[0])
    );

    md_router #(.DW(16), .NCH(3), .MODE(1), .SEL_LSB(0), .BURST_LEN(3)) u_rt (
        .clk(clk), .reset(reset),
        .AXIS_IN_MD_TDATA(in_data[1]), .AXIS_IN_MD_TVALID(in_valid[1]), .AXIS_IN_MD_TREADY(in_ready[1]),
        .AXIS_OUT_MD_TDATA(out_data[1]), .AXIS_OUT_MD_TVALID(out_valid[1]),
        .AXIS_OUT_MD_TREADY(out_ready[1]), .AXIS_OUT_MD_TLAST(out_last[1]),
        .stat_beats(sb[1]), .stat_drops(sd[1])
    );

    // Reference model: each channel is a one-beat slot; a beat's TLAST comes from its per-channel ordinal modulo BURST_LEN.
    task automatic scoreboard();
        for (int d = 0; d < 2; d++) begin
            int          bl;
            int          s;
            logic        e;
            logic [31:0] eb;
            logic [31:0] ed;
            bl = d == 1 ? 3 : 4;
            if (reset) begin
                total++;
                if (out_valid[d] !== 3'b0 || out_last[d] !== 3'b0 || out_data[d] !== 48'b0) begin
                    bad++;
                    $display("FAIL reset_outputs dut=%0d got valid=%b last=%b data=%h expected all zero",
                             d, out_valid[d], out_last[d], out_data[d]);
                end
                occ[d] = '0;
                mdrop[d] = 0;
                for (int c = 0; c < 3; c++) begin
                    mc[d][c] = 0;
                    mb[d][c] = 0;
                end
            end else begin
                s = int'(in_data[d][1:0]);
                e = d == 0 ? &(~occ[d] | out_ready[d]) : (s < 3 ? (!occ[d][s] || out_ready[d][s]) : 1'b1);
                total++;
                if (in_ready[d] !== e) begin
                    bad++;
                    $display("FAIL in_ready dut=%0d got %b expected %b", d, in_ready[d], e);
                end
                for (int c = 0; c < 3; c++) begin
                    total++;
                    if (out_valid[d][c] !== occ[d][c]) begin
                        bad++;
                        $display("FAIL out_valid dut=%0d ch=%0d got %b expected %b", d, c, out_valid[d][c], occ[d][c]);
                    end
                    if (occ[d][c]) begin
                        total++;
                        if (out_data[d][c*16 +: 16] !== md[d][c] || out_last[d][c] !== ml[d][c]) begin
                            bad++;
                            $display("FAIL out_beat dut=%0d ch=%0d got data=%h last=%b expected data=%h last=%b",
                                     d, c, out_data[d][c*16 +: 16], out_last[d][c], md[d][c], ml[d][c]);
                        end
                    end
`ifdef MD_ROUTER_STATS_EN
                    eb = 32'(mb[d][c]);
`else
                    eb = 32'd0;
`endif
                    total++;
                    if (sb[d][c*32 +: 32] !== eb) begin
                        bad++;
                        $display("FAIL stat_beats dut=%0d ch=%0d got %0d expected %0d", d, c, sb[d][c*32 +: 32], eb);
                    end
                end
`ifdef MD_ROUTER_STATS_EN
                ed = 32'(mdrop[d]);
`else
                ed = 32'd0;
`endif
                total++;
                if (sd[d] !== ed) begin
                    bad++;
                    $display("FAIL stat_drops dut=%0d got %0d expected %0d", d, sd[d], ed);
                end
                for (int c = 0; c < 3; c++) begin
                    if (occ[d][c] && out_ready[d][c]) begin
                        occ[d][c] = 1'b0;
                        mb[d][c]++;
                    end
                end
                if (in_valid[d] && e) begin
                    if (d == 1 && s >= 3) mdrop[d]++;
                    else begin
                        for (int c = 0; c < 3; c++) begin
                            if (d == 0 || s == c) begin
                                occ[d][c] = 1'b1;
                                md[d][c] = in_data[d];
                                ml[d][c] = mc[d][c] == bl - 1;
                                mc[d][c] = (mc[d][c] + 1) % bl;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            scoreboard();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        total++;
        if (out_valid[0] !== 3'b0 || out_valid[1] !== 3'b0 || in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got valid0=%b valid1=%b rdy0=%b rdy1=%b expected 000 000 1 1",
                     out_valid[0], out_valid[1], in_ready[0], in_ready[1]);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_broadcast();
        out_ready[0] = 3'b111;
        for (int i = 1; i <= 8; i++) begin
            in_valid[0] = 1'b1;
            in_data[0] = 16'(i);
            cyc(1);
            for (int c = 0; c < 3; c++) begin
                total++;
                if (out_valid[0][c] !== 1'b1 || out_data[0][c*16 +: 16] !== 16'(i) || out_last[0][c] !== (i % 4 == 0)) begin
                    bad++;
                    $display("FAIL broadcast beat=%0d ch=%0d got valid=%b data=%h last=%b expected 1 %h %b",
                             i, c, out_valid[0][c], out_data[0][c*16 +: 16], out_last[0][c], 16'(i), i % 4 == 0);
                end
            end
        end
        in_valid[0] = 1'b0;
        cyc(2);
    endtask

    task automatic test_stall();
        out_ready[0] = 3'b101;
        in_valid[0] = 1'b1;
        in_data[0] = 16'h0020;
        cyc(1);
        in_data[0] = 16'h0021;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (in_ready[0] !== 1'b0 || out_valid[0][1] !== 1'b1 || out_data[0][31:16] !== 16'h0020) begin
                bad++;
                $display("FAIL stall cycle=%0d got rdy=%b v1=%b d1=%h expected 0 1 0020",
                         k, in_ready[0], out_valid[0][1], out_data[0][31:16]);
            end
            cyc(1);
        end
        out_ready[0] = 3'b111;
        #1;
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got rdy=%b expected 1", in_ready[0]);
        end
        cyc(1);
        total++;
        if (out_valid[0] !== 3'b111 || out_data[0] !== {3{16'h0021}}) begin
            bad++;
            $display("FAIL stall_resume got valid=%b data=%h expected 111 %h", out_valid[0], out_data[0], {3{16'h0021}});
        end
        in_valid[0] = 1'b0;
        cyc(2);
    endtask

    task automatic test_route();
        int   sels [5];
        logic lasts [5];
        logic [15:0] v;
        sels = '{0, 1, 0, 2, 0};
        lasts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready[1] = 3'b111;
        for (int i = 0; i < 5; i++) begin
            v = 16'(((i + 1) << 8) | sels[i]);
            in_valid[1] = 1'b1;
            in_data[1] = v;
            cyc(1);
            total++;
            if (out_valid[1] !== (3'b001 << sels[i]) || out_data[1][sels[i]*16 +: 16] !== v || out_last[1][sels[i]] !== lasts[i]) begin
                bad++;
                $display("FAIL route beat=%0d got valid=%b data=%h last=%b expected %b %h %b",
                         i, out_valid[1], out_data[1][sels[i]*16 +: 16], out_last[1][sels[i]], 3'b001 << sels[i], v, lasts[i]);
            end
        end
        in_valid[1] = 1'b0;
        cyc(2);
    endtask

    task automatic test_drop();
        out_ready[1] = 3'b111;
        in_valid[1] = 1'b1;
        in_data[1] = 16'h0703;
        #1;
        total++;
        if (in_ready[1] !== 1'b1) begin
            bad++;
            $display("FAIL drop_ready got %b expected 1", in_ready[1]);
        end
        cyc(1);
        in_valid[1] = 1'b0;
        total++;
        if (out_valid[1] !== 3'b000) begin
            bad++;
            $display("FAIL drop_valid got %b expected 000", out_valid[1]);
        end
`ifdef MD_ROUTER_STATS_EN
        total++;
        if (sd[1] !== 32'd1) begin
            bad++;
            $display("FAIL drop_count got %0d expected 1", sd[1]);
        end
`endif
        cyc(2);
    endtask

    task automatic test_block();
        out_ready[1] = 3'b011;
        in_valid[1] = 1'b1;
        in_data[1] = 16'h0502;
        cyc(1);
        in_data[1] = 16'h0602;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (in_ready[1] !== 1'b0 || out_valid[1][2] !== 1'b1 || out_data[1][47:32] !== 16'h0502) begin
                bad++;
                $display("FAIL block cycle=%0d got rdy=%b v2=%b d2=%h expected 0 1 0502",
                         k, in_ready[1], out_valid[1][2], out_data[1][47:32]);
            end
            cyc(1);
        end
        out_ready[1] = 3'b111;
        #1;
        total++;
        if (in_ready[1] !== 1'b1) begin
            bad++;
            $display("FAIL block_release got rdy=%b expected 1", in_ready[1]);
        end
        cyc(1);
        total++;
        if (out_valid[1][2] !== 1'b1 || out_data[1][47:32] !== 16'h0602) begin
            bad++;
            $display("FAIL block_resume got v2=%b d2=%h expected 1 0602", out_valid[1][2], out_data[1][47:32]);
        end
        in_valid[1] = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid();
        out_ready[0] = 3'b111;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[0] = 1'b1;
            in_data[0] = 16'(16'h0040 + i);
            cyc(1);
        end
        reset = 1'b1;
        #1;
        total++;
        if (out_valid[0] !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_valid got %b expected 000", out_valid[0]);
        end
        in_valid[0] = 1'b0;
        cyc(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1;
            in_data[0] = 16'(16'h0050 + i);
            cyc(1);
            total++;
            if (out_valid[0] !== 3'b111 || out_last[0] !== {3{i == 3}}) begin
                bad++;
                $display("FAIL reset_mid_frame beat=%0d got valid=%b last=%b expected 111 %b",
                         i, out_valid[0], out_last[0], {3{i == 3}});
            end
        end
        in_valid[0] = 1'b0;
        cyc(2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d] = ($urandom % 4) != 0;
                in_data[d] = 16'($urandom);
                out_ready[d] = 3'($urandom) | 3'($urandom);
            end
            cyc(1);
        end
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 3'b111;
        end
        cyc(3);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_data[d] = '0;
            out_ready[d] = 3'b111;
        end
        test_reset();
        test_broadcast();
        test_stall();
        test_route();
        test_drop();
        test_block();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
